// File: rtl/alu_pkg.sv
// Types shared by the ALU and its command issuer: opcodes, response status,
// issuer FSM states and the legal-opcode check.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD            = 4'd0,
    SUBTRACT       = 4'd1,
    XOR            = 4'd2,
    OR             = 4'd3,
    AND            = 4'd4,
    SHIFT_LT_LOG   = 4'd5,
    SHIFT_RT_LOG   = 4'd6,
    SHIFT_RT_AR    = 4'd7,
    IS_EQUAL       = 4'd8,
    IS_GREATER     = 4'd9,
    BARREL_SHIFTER = 4'd10,
    ROTATE_LT      = 4'd11,
    ROTATE_RT      = 4'd12,
    MULTIPLY       = 4'd13
  } op_code_t;

  typedef enum logic [1:0] {
    OK         = 2'd0,
    ILLEGAL_OP = 2'd1,
    TIMEOUT    = 2'd2
  } rsp_status_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } issuer_state_t;

  // Opcodes the attached ALU actually implements; anything else is refused.
  function automatic logic is_legal_op(op_code_t op);
    case (op)
      ADD, SUBTRACT, XOR, OR, AND,
      SHIFT_LT_LOG, SHIFT_RT_LOG, SHIFT_RT_AR,
      IS_EQUAL, IS_GREATER: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command stream, ALU input/output pair and response stream of the issuer.
// master = issuer side, slave = upstream/ALU/downstream side.
interface alu_cmd_issuer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  import alu_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  op_code_t              cmd_op;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic [TAG_WIDTH-1:0]  cmd_tag;

  logic                  inputs_valid;
  op_code_t              op_code;
  logic [DATA_WIDTH-1:0] input_A;
  logic [DATA_WIDTH-1:0] input_B;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  rsp_status_t           rsp_status;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    output cmd_ready,
    output inputs_valid, op_code, input_A, input_B,
    input  result, result_valid,
    output rsp_valid, rsp_result, rsp_tag, rsp_status,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    input  cmd_ready,
    input  inputs_valid, op_code, input_A, input_B,
    output result, result_valid,
    input  rsp_valid, rsp_result, rsp_tag, rsp_status,
    output rsp_ready
  );

endinterface

// File: rtl/alu_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module alu_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to the ALU, waits for its result (with timeout)
// and returns result/tag/status downstream. All outputs come straight from flops.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 8,   // must be >= 2
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_cmd_issuer_if.master     bus,
  output logic [CNT_WIDTH-1:0] cnt_issued,
  output logic [CNT_WIDTH-1:0] cnt_timeout,
  output logic [CNT_WIDTH-1:0] cnt_spurious
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
  // The response flop adds one cycle after the decision, so expiring at
  // TIMEOUT_CYCLES-2 puts rsp_valid exactly TIMEOUT_CYCLES after WAIT entry.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);

  issuer_state_t         state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  inputs_valid_q, inputs_valid_d;
  op_code_t              op_code_q, op_code_d;
  logic [DATA_WIDTH-1:0] input_a_q, input_a_d;
  logic [DATA_WIDTH-1:0] input_b_q, input_b_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  rsp_status_t           rsp_status_q, rsp_status_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  issue_inc, timeout_inc, spurious_inc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cmd_ready_q    <= 1'b0;
      inputs_valid_q <= 1'b0;
      op_code_q      <= ADD;
      input_a_q      <= '0;
      input_b_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_tag_q      <= '0;
      rsp_status_q   <= OK;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      inputs_valid_q <= inputs_valid_d;
      op_code_q      <= op_code_d;
      input_a_q      <= input_a_d;
      input_b_q      <= input_b_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_tag_q      <= rsp_tag_d;
      rsp_status_q   <= rsp_status_d;
      timer_q        <= timer_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d        = state_q;
    cmd_ready_d    = 1'b0;
    inputs_valid_d = 1'b0;
    op_code_d      = op_code_q;
    input_a_d      = input_a_q;
    input_b_d      = input_b_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_tag_d      = rsp_tag_q;
    rsp_status_d   = rsp_status_q;
    timer_d        = timer_q;
    issue_inc      = 1'b0;
    timeout_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          rsp_tag_d = bus.cmd_tag;
          if (is_legal_op(bus.cmd_op)) begin
            state_d        = ISSUE;
            inputs_valid_d = 1'b1;
            op_code_d      = bus.cmd_op;
            input_a_d      = bus.cmd_a;
            input_b_d      = bus.cmd_b;
          end else begin
            // Refused without touching the ALU-facing registers.
            state_d      = RESPOND;
            rsp_status_d = ILLEGAL_OP;
            rsp_result_d = '0;
          end
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        timer_d   = '0;
        issue_inc = 1'b1;
      end
      WAIT: begin
        if (bus.result_valid) begin
          state_d      = RESPOND;
          rsp_status_d = OK;
          rsp_result_d = bus.result;
        end else if (timer_q == TIMER_LAST) begin
          state_d      = RESPOND;
          rsp_status_d = TIMEOUT;
          rsp_result_d = '0;
          timeout_inc  = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      RESPOND: begin
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  assign spurious_inc = bus.result_valid && (state_q != WAIT);

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.inputs_valid = inputs_valid_q;
  assign bus.op_code      = op_code_q;
  assign bus.input_A      = input_a_q;
  assign bus.input_B      = input_b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign bus.rsp_status   = rsp_status_q;

  alu_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_issued (
    .clk(clk), .reset_n(reset_n), .inc(issue_inc), .count(cnt_issued)
  );

  alu_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_timeout (
    .clk(clk), .reset_n(reset_n), .inc(timeout_inc), .count(cnt_timeout)
  );

  alu_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_spurious (
    .clk(clk), .reset_n(reset_n), .inc(spurious_inc), .count(cnt_spurious)
  );

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed and randomized bench for alu_cmd_issuer with a behavioural ALU
// responder and an arithmetic reference model.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int TO = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [CW-1:0] cnt_issued, cnt_timeout, cnt_spurious;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_issued = 0, exp_timeout = 0, exp_spurious = 0;
  int exp_pulses = 0;
  int iv_count = 0;
  logic suppress = 1'b0;
  logic stray = 1'b0;
  op_code_t last_op = ADD;
  logic [DW-1:0] last_a = '0, last_b = '0;

  alu_cmd_issuer_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus();

  alu_cmd_issuer #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .cnt_issued(cnt_issued),
    .cnt_timeout(cnt_timeout),
    .cnt_spurious(cnt_spurious)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_ref(op_code_t op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      ADD:          return a + b;
      SUBTRACT:     return a - b;
      XOR:          return a ^ b;
      OR:           return a | b;
      AND:          return a & b;
      SHIFT_LT_LOG: return a << b[4:0];
      SHIFT_RT_LOG: return a >> b[4:0];
      SHIFT_RT_AR:  return $signed(a) >>> b[4:0];
      IS_EQUAL:     return {{(DW-1){1'b0}}, (a == b)};
      IS_GREATER:   return {{(DW-1){1'b0}}, (a > b)};
      default:      return '0;
    endcase
  endfunction

  function automatic logic tb_legal(op_code_t op);
    return op inside {ADD, SUBTRACT, XOR, OR, AND, SHIFT_LT_LOG,
                      SHIFT_RT_LOG, SHIFT_RT_AR, IS_EQUAL, IS_GREATER};
  endfunction

  // ALU responder: one-cycle result_valid after inputs_valid, unless suppressed.
  always @(posedge clk) begin
    bus.result_valid <= (bus.inputs_valid && !suppress) || stray;
    bus.result       <= alu_ref(bus.op_code, bus.input_A, bus.input_B);
    if (bus.inputs_valid === 1'b1) iv_count <= iv_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_inputs_valid", bus.inputs_valid, 0);
    check("rst_rsp_valid",    bus.rsp_valid, 0);
    check("rst_cmd_ready",    bus.cmd_ready, 0);
    check("rst_op_code",      bus.op_code, ADD);
    check("rst_input_A",      bus.input_A, 0);
    check("rst_input_B",      bus.input_B, 0);
    check("rst_rsp_result",   bus.rsp_result, 0);
    check("rst_rsp_tag",      bus.rsp_tag, 0);
    check("rst_rsp_status",   bus.rsp_status, OK);
    check("rst_cnt_issued",   cnt_issued, 0);
    check("rst_cnt_timeout",  cnt_timeout, 0);
    check("rst_cnt_spurious", cnt_spurious, 0);
  endtask

  // Present a command at a negedge, wait for acceptance, check the ALU drive
  // at the first negedge after the accepting edge. Returns at that negedge.
  task automatic send(input op_code_t op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag, input bit hold);
    int n = 0;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_tag = tag;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", bus.cmd_ready, 1);
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
    check("issue_pulse", bus.inputs_valid, tb_legal(op));
    if (tb_legal(op)) begin
      last_op = op; last_a = a; last_b = b;
      exp_issued++;
      exp_pulses++;
    end
    check("issue_op_code", bus.op_code, last_op);
    check("issue_input_A", bus.input_A, last_a);
    check("issue_input_B", bus.input_B, last_b);
  endtask

  // Wait for the response (latency counted from the negedge after acceptance),
  // hold rsp_ready low for ready_delay cycles, then complete the handshake.
  task automatic collect(input logic [DW-1:0] exp_res, input logic [TW-1:0] exp_tag,
                         input rsp_status_t exp_st, input int exp_lat, input int ready_delay);
    int lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency",   lat, exp_lat);
    check("rsp_result",    bus.rsp_result, exp_res);
    check("rsp_tag",       bus.rsp_tag, exp_tag);
    check("rsp_status",    bus.rsp_status, exp_st);
    check("busy_no_ready", bus.cmd_ready, 0);
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      check("stall_rsp_valid",  bus.rsp_valid, 1);
      check("stall_rsp_result", bus.rsp_result, exp_res);
      check("stall_rsp_tag",    bus.rsp_tag, exp_tag);
      check("stall_cmd_ready",  bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_dropped",  bus.rsp_valid, 0);
    check("ready_back",   bus.cmd_ready, 1);
    check("cnt_issued",   cnt_issued, exp_issued);
    check("cnt_timeout",  cnt_timeout, exp_timeout);
    check("cnt_spurious", cnt_spurious, exp_spurious);
    check("alu_pulses",   iv_count, exp_pulses);
  endtask

  task automatic stray_pulse();
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    exp_spurious++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_code_t op;
    logic [DW-1:0] a, b;
    logic [TW-1:0] tag;
    bit sup;
    int dly;

    bus.cmd_valid = 1'b0; bus.cmd_op = ADD; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_tag = '0; bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_state();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", bus.cmd_ready, 1);

    // 1: basic ADD
    send(ADD, 32'd5, 32'd3, 4'd2, 1'b0);
    collect(32'd8, 4'd2, OK, 3, 0);

    // 2: back-to-back with cmd_valid held, responses in order
    send(SUBTRACT, 32'd10, 32'd4, 4'd1, 1'b1);
    bus.cmd_op = IS_GREATER; bus.cmd_a = 32'd7; bus.cmd_b = 32'd9; bus.cmd_tag = 4'd3;
    collect(32'd6, 4'd1, OK, 3, 0);
    send(IS_GREATER, 32'd7, 32'd9, 4'd3, 1'b0);
    collect(32'd0, 4'd3, OK, 3, 0);

    // 3: illegal opcode never reaches the ALU
    send(BARREL_SHIFTER, 32'd1, 32'd2, 4'd7, 1'b0);
    collect(32'd0, 4'd7, ILLEGAL_OP, 1, 0);

    // 4: timeout, then a stray result_valid
    suppress = 1'b1;
    send(ADD, 32'd100, 32'd200, 4'd4, 1'b0);
    exp_timeout++;
    collect(32'd0, 4'd4, TIMEOUT, TO + 1, 0);
    suppress = 1'b0;
    stray_pulse();
    repeat (3) begin
      @(negedge clk);
      check("no_rsp_after_stray", bus.rsp_valid, 0);
    end
    check("stray_cnt_spurious", cnt_spurious, exp_spurious);

    // 5: downstream back-pressure
    send(SHIFT_LT_LOG, 32'd1, 32'd4, 4'd5, 1'b0);
    collect(32'd16, 4'd5, OK, 3, 10);

    // 6: reset while waiting for the ALU
    suppress = 1'b1;
    send(ADD, 32'd9, 32'd9, 4'd6, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    reset_n = 1'b1;
    suppress = 1'b0;
    exp_issued = 0; exp_timeout = 0; exp_spurious = 0;
    last_op = ADD; last_a = '0; last_b = '0;
    repeat (4) begin
      @(negedge clk);
      check("no_rsp_after_reset", bus.rsp_valid, 0);
    end
    send(ADD, 32'd1, 32'd1, 4'd8, 1'b0);
    collect(32'd2, 4'd8, OK, 3, 0);

    // Randomized commands against the reference model
    for (int it = 0; it < 30; it++) begin
      op  = op_code_t'(4'($urandom_range(0, 15)));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      tag = 4'($urandom_range(0, 15));
      sup = tb_legal(op) && ($urandom_range(0, 5) == 0);
      dly = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) stray_pulse();
      suppress = sup;
      send(op, a, b, tag, 1'b0);
      if (!tb_legal(op)) begin
        collect('0, tag, ILLEGAL_OP, 1, dly);
      end else if (sup) begin
        exp_timeout++;
        collect('0, tag, TIMEOUT, TO + 1, dly);
      end else begin
        collect(alu_ref(op, a, b), tag, OK, 3, dly);
      end
      suppress = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
